converter_controller: RTL and testbench

Sequencing controller for `converter_datapath`. It accepts one conversion request at a time over a valid/ready handshake and latches the opcode and operand. It drives the datapath's operand inputs, opcode and engine start pulses, then waits for completion and registers all four result views. It returns them over a valid/ready response handshake, with an error flag for illegal opcodes and engine timeouts.

---
 rtl/converter_pkg.sv | 30 +++
 rtl/converter_watchdog.sv | 40 ++++
 rtl/converter_controller.sv | 171 +++++++++++++++++
 tb/tb_converter_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/converter_pkg.sv
// Shared opcodes, opcode predicates and controller state encoding for the converter block.
package converter_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_BIN2GRAY = 3'd0;
  localparam logic [OP_W-1:0] OP_GRAY2BIN = 3'd1;
  localparam logic [OP_W-1:0] OP_BIN2BCD  = 3'd2;
  localparam logic [OP_W-1:0] OP_BCD2BIN  = 3'd3;
  localparam logic [OP_W-1:0] OP_BCD2EX3  = 3'd4;
  localparam logic [OP_W-1:0] OP_EX32BCD  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } ctrl_state_t;

  // Opcodes served by a multi-cycle engine that needs a start pulse and done wait.
  function automatic logic op_is_seq(input logic [OP_W-1:0] op);
    return (op == OP_BIN2BCD) || (op == OP_BCD2BIN);
  endfunction

  // Opcodes 6 and 7 are unassigned.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_EX32BCD;
  endfunction

endpackage

// File: rtl/converter_watchdog.sv
// Cycle watchdog: counts enabled cycles after a clear and flags the cycle the count hits TIMEOUT-1.
module converter_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // Saturating increment so the count never wraps back below LAST.
  always_comb begin
    cnt_d = cnt;
    if (cnt != LAST) begin
      cnt_d = cnt + CW'(1);
    end
  end

  // expired is registered against the next count so it is valid in the same cycle the count equals LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_d;
      expired <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/converter_controller.sv
// Request/response sequencer for converter_datapath: launches an op, waits for completion, returns all views.
module converter_controller
  import converter_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned DIGITS  = 3,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned BW      = DIGITS * 4,
  localparam int unsigned DW      = (WIDTH > BW) ? WIDTH : BW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [DW-1:0]   req_data,
  output logic [OP_W-1:0] dp_op,
  output logic [WIDTH-1:0] dp_bin_in,
  output logic [WIDTH-1:0] dp_gray_in,
  output logic [BW-1:0]   dp_bcd_in,
  output logic [BW-1:0]   dp_ex3_in,
  output logic            dp_start_bin2bcd,
  output logic            dp_start_bcd2bin,
  input  logic            dp_done_any,
  input  logic            dp_busy_any,
  input  logic [WIDTH-1:0] dp_bin_out,
  input  logic [WIDTH-1:0] dp_gray_out,
  input  logic [BW-1:0]   dp_bcd_out,
  input  logic [BW-1:0]   dp_ex3_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WIDTH-1:0] rsp_bin,
  output logic [WIDTH-1:0] rsp_gray,
  output logic [BW-1:0]   rsp_bcd,
  output logic [BW-1:0]   rsp_ex3,
  output logic            rsp_err,
  output logic [OP_W-1:0] rsp_op
);

  ctrl_state_t     state;
  ctrl_state_t     state_d;
  logic [OP_W-1:0] op_q;
  logic [DW-1:0]   data_q;
  logic            accept;
  logic            rsp_load;
  logic            rsp_fail;
  logic            wd_clear;
  logic            wd_en;
  logic            wd_expired;
  logic            unused_busy;

  // Busy is informational only; it does not steer the sequencer.
  assign unused_busy = dp_busy_any;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode plus state-decoded handshake, start and watchdog controls.
  always_comb begin
    state_d          = state;
    accept           = 1'b0;
    rsp_load         = 1'b0;
    rsp_fail         = 1'b0;
    wd_clear         = 1'b0;
    wd_en            = 1'b0;
    req_ready        = 1'b0;
    dp_start_bin2bcd = 1'b0;
    dp_start_bcd2bin = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = rst;
        accept    = req_valid;
        if (req_valid) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_clear = 1'b1;
        if (!op_is_legal(op_q)) begin
          rsp_load = 1'b1;
          rsp_fail = 1'b1;
          state_d  = ST_RESP;
        end else if (op_is_seq(op_q)) begin
          dp_start_bin2bcd = (op_q == OP_BIN2BCD);
          dp_start_bcd2bin = (op_q == OP_BCD2BIN);
          state_d          = ST_WAIT;
        end else begin
          rsp_load = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        if (dp_done_any) begin
          rsp_load = 1'b1;
          state_d  = ST_RESP;
        end else if (wd_expired) begin
          rsp_load = 1'b1;
          rsp_fail = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latch; held through LAUNCH, WAIT and RESP so datapath operands stay stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      data_q <= req_data;
    end
  end

  assign dp_op      = op_q;
  assign dp_bin_in  = data_q[WIDTH-1:0];
  assign dp_gray_in = data_q[WIDTH-1:0];
  assign dp_bcd_in  = data_q[BW-1:0];
  assign dp_ex3_in  = data_q[BW-1:0];

  // Response registers: loaded on entry to RESP (zeroed on error), released on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_op    <= '0;
      rsp_bin   <= '0;
      rsp_gray  <= '0;
      rsp_bcd   <= '0;
      rsp_ex3   <= '0;
    end else if (rsp_load) begin
      rsp_valid <= 1'b1;
      rsp_err   <= rsp_fail;
      rsp_op    <= op_q;
      rsp_bin   <= rsp_fail ? '0 : dp_bin_out;
      rsp_gray  <= rsp_fail ? '0 : dp_gray_out;
      rsp_bcd   <= rsp_fail ? '0 : dp_bcd_out;
      rsp_ex3   <= rsp_fail ? '0 : dp_ex3_out;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Engine timeout supervision during WAIT.
  converter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

endmodule

// File: tb/tb_converter_controller.sv
// Scoreboard bench for converter_controller against a behavioural datapath stub.
module tb_converter_controller;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DIGITS  = 3;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned BW      = DIGITS * 4;
  localparam int unsigned DW      = 12;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DW-1:0]     req_data;
  logic [2:0]        dp_op;
  logic [WIDTH-1:0]  dp_bin_in, dp_gray_in;
  logic [BW-1:0]     dp_bcd_in, dp_ex3_in;
  logic              dp_start_bin2bcd, dp_start_bcd2bin;
  logic              dp_done_any, dp_busy_any;
  logic [WIDTH-1:0]  dp_bin_out, dp_gray_out;
  logic [BW-1:0]     dp_bcd_out, dp_ex3_out;
  logic              rsp_valid, rsp_ready;
  logic [WIDTH-1:0]  rsp_bin, rsp_gray;
  logic [BW-1:0]     rsp_bcd, rsp_ex3;
  logic              rsp_err;
  logic [2:0]        rsp_op;

  typedef struct {
    logic [2:0]  op;
    logic        err;
    logic [7:0]  bin;
    logic [7:0]  gray;
    logic [11:0] bcd;
    logic [11:0] ex3;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_b2b = 0;
  int   n_bcd2b = 0;
  int   seq_lat = 1;
  int   eng_left = 0;

  converter_controller #(
    .WIDTH   (WIDTH),
    .DIGITS  (DIGITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_data         (req_data),
    .dp_op            (dp_op),
    .dp_bin_in        (dp_bin_in),
    .dp_gray_in       (dp_gray_in),
    .dp_bcd_in        (dp_bcd_in),
    .dp_ex3_in        (dp_ex3_in),
    .dp_start_bin2bcd (dp_start_bin2bcd),
    .dp_start_bcd2bin (dp_start_bcd2bin),
    .dp_done_any      (dp_done_any),
    .dp_busy_any      (dp_busy_any),
    .dp_bin_out       (dp_bin_out),
    .dp_gray_out      (dp_gray_out),
    .dp_bcd_out       (dp_bcd_out),
    .dp_ex3_out       (dp_ex3_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_bin          (rsp_bin),
    .rsp_gray         (rsp_gray),
    .rsp_bcd          (rsp_bcd),
    .rsp_ex3          (rsp_ex3),
    .rsp_err          (rsp_err),
    .rsp_op           (rsp_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [11:0] b2bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return {4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic logic [7:0] bcd2b(input logic [11:0] d);
    return 8'(int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]));
  endfunction

  // Engine stub: done pulses seq_lat cycles after the start pulse; seq_lat of 0 means never.
  always @(posedge clk or negedge rst) begin
    if (!rst) eng_left <= 0;
    else if (dp_start_bin2bcd || dp_start_bcd2bin) eng_left <= seq_lat;
    else if (eng_left > 0) eng_left <= eng_left - 1;
  end
  assign dp_done_any = (eng_left == 1);
  assign dp_busy_any = (eng_left > 1);

  // Datapath view stub; sequential results are only valid while done is high.
  always_comb begin
    dp_bin_out  = '0;
    dp_gray_out = '0;
    dp_bcd_out  = '0;
    dp_ex3_out  = '0;
    case (dp_op)
      3'd0: dp_gray_out = dp_bin_in ^ (dp_bin_in >> 1);
      3'd1: dp_bin_out  = g2b(dp_gray_in);
      3'd2: dp_bcd_out  = dp_done_any ? b2bcd(dp_bin_in) : 12'hEEE;
      3'd3: dp_bin_out  = dp_done_any ? bcd2b(dp_bcd_in) : 8'hEE;
      3'd4: dp_ex3_out  = dp_bcd_in + 12'h333;
      3'd5: dp_bcd_out  = dp_ex3_in - 12'h333;
      default: begin
        dp_bin_out  = 8'h5A;
        dp_gray_out = 8'h5A;
        dp_bcd_out  = 12'h5A5;
        dp_ex3_out  = 12'h5A5;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic err, input logic [7:0] bin,
                              input logic [7:0] gray, input logic [11:0] bcd,
                              input logic [11:0] ex3, input int lat);
    exp_t e;
    e.op = op; e.err = err; e.bin = bin; e.gray = gray; e.bcd = bcd; e.ex3 = ex3; e.lat = lat;
    return e;
  endfunction

  // Monitor: records accept cycles, pops the scoreboard on each rising rsp_valid.
  initial begin : monitor
    exp_t e;
    int   acc;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (dp_start_bin2bcd) n_b2b++;
        if (dp_start_bcd2bin) n_bcd2b++;
        if (dp_start_bin2bcd && dp_start_bcd2bin) begin
          fails++;
          $display("FAIL start_overlap: both start pulses high at cycle %0d", cyc);
        end
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (rsp_valid && !prev) begin
          if (sb_q.size() == 0 || acc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: rsp_valid rose with nothing pending at cycle %0d", cyc);
          end else begin
            e   = sb_q.pop_front();
            acc = acc_q.pop_front();
            chk("latency", 32'(cyc - acc), 32'(e.lat));
            chk("rsp_op",   32'(rsp_op),   32'(e.op));
            chk("rsp_err",  32'(rsp_err),  32'(e.err));
            chk("rsp_bin",  32'(rsp_bin),  32'(e.bin));
            chk("rsp_gray", 32'(rsp_gray), 32'(e.gray));
            chk("rsp_bcd",  32'(rsp_bcd),  32'(e.bcd));
            chk("rsp_ex3",  32'(rsp_ex3),  32'(e.ex3));
          end
        end
        prev = rsp_valid;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [11:0] data, input exp_t e);
    bit ok;
    ok = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = (sb_q.size() == 0) && !rsp_valid && req_ready;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain_wait: response still pending after 100 cycles");
    end
  endtask

  initial begin : stim
    int  b0;
    int  c0;
    bit  seen;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);
    chk("post_reset_dp_op", 32'(dp_op), 32'd0);

    // Combinational ops
    send(3'd0, 12'h0A5, mk(3'd0, 1'b0, 8'h00, 8'hF7, 12'h000, 12'h000, 2));
    drain();
    send(3'd1, 12'h0F7, mk(3'd1, 1'b0, 8'hA5, 8'h00, 12'h000, 12'h000, 2));
    drain();
    send(3'd4, 12'h097, mk(3'd4, 1'b0, 8'h00, 8'h00, 12'h000, 12'h3CA, 2));
    drain();

    // BIN2BCD, engine done 3 cycles after start
    b0 = n_b2b; c0 = n_bcd2b;
    seq_lat = 3;
    send(3'd2, 12'h0FF, mk(3'd2, 1'b0, 8'h00, 8'h00, 12'h255, 12'h000, 5));
    drain();
    chk("bin2bcd_pulses", 32'(n_b2b - b0), 32'd1);
    chk("bin2bcd_no_other", 32'(n_bcd2b - c0), 32'd0);

    // BCD2BIN then EX32BCD
    b0 = n_b2b; c0 = n_bcd2b;
    seq_lat = 1;
    send(3'd3, 12'h199, mk(3'd3, 1'b0, 8'hC7, 8'h00, 12'h000, 12'h000, 3));
    drain();
    chk("bcd2bin_pulses", 32'(n_bcd2b - c0), 32'd1);
    send(3'd5, 12'h48B, mk(3'd5, 1'b0, 8'h00, 8'h00, 12'h158, 12'h000, 2));
    drain();

    // Illegal opcodes: error, zeroed data, no starts
    b0 = n_b2b; c0 = n_bcd2b;
    send(3'd6, 12'hFFF, mk(3'd6, 1'b1, 8'h00, 8'h00, 12'h000, 12'h000, 2));
    drain();
    send(3'd7, 12'h123, mk(3'd7, 1'b1, 8'h00, 8'h00, 12'h000, 12'h000, 2));
    drain();
    chk("illegal_no_starts", 32'((n_b2b - b0) + (n_bcd2b - c0)), 32'd0);

    // Done in the same cycle the watchdog expires: done wins
    seq_lat = TIMEOUT;
    send(3'd3, 12'h100, mk(3'd3, 1'b0, 8'h64, 8'h00, 12'h000, 12'h000, 10));
    drain();
    // Done one cycle too late: timeout
    seq_lat = TIMEOUT + 1;
    send(3'd2, 12'h063, mk(3'd2, 1'b1, 8'h00, 8'h00, 12'h000, 12'h000, 10));
    drain();

    // Engine never finishes, consumer stalls 5 cycles
    seq_lat = 0;
    rsp_ready = 1'b0;
    send(3'd2, 12'h02A, mk(3'd2, 1'b1, 8'h00, 8'h00, 12'h000, 12'h000, 10));
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("timeout_rsp_seen", 32'(seen), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_err", 32'(rsp_err), 32'd1);
      chk("stall_rsp_bcd", 32'(rsp_bcd), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    drain();

    // Reset in the middle of WAIT
    b0 = n_b2b;
    send(3'd2, 12'h011, mk(3'd2, 1'b0, 8'h00, 8'h00, 12'h017, 12'h000, 0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    sb_q.delete();
    acc_q.delete();
    chk("midwait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midwait_rst_starts", 32'({dp_start_bin2bcd, dp_start_bcd2bin}), 32'd0);
    chk("midwait_rst_req_ready", 32'(req_ready), 32'd0);
    chk("midwait_rst_dp_op", 32'(dp_op), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    send(3'd0, 12'h03C, mk(3'd0, 1'b0, 8'h00, 8'h22, 12'h000, 12'h000, 2));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
